// File: rtl/ps2_host_tx_pkg.sv
// Shared types, codes and helpers for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  localparam int unsigned CNT_W   = 20;
  localparam int unsigned FRAME_W = 9;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_NO_ACK   = 2'b01;
  localparam logic [1:0] ERR_START_TO = 2'b10;
  localparam logic [1:0] ERR_XFER_TO  = 2'b11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Odd parity in bit 8, payload LSB first in bits 7:0.
  function automatic logic [FRAME_W-1:0] frame_bits(input logic [7:0] data);
    return {~^data, data};
  endfunction

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for one PS/2 pin plus a falling-edge strobe.
module ps2_host_tx_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic fall_c_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o  = sync2_q;
  assign fall_c_o = prev_q & ~sync2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data + parity + stop,
// device ACK check, with start and transfer watchdogs. Drives both pins open-drain.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 5500,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  localparam cnt_t       INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam cnt_t       START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam cnt_t       XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] PARITY_IDX = 4'd8;

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;

  ps2_host_tx_line_sync u_clk_sync (
    .clock    (clock),
    .reset    (reset),
    .pin_i    (ps2_clk_in),
    .level_o  (clk_level),
    .fall_c_o (clk_fall)
  );

  ps2_host_tx_line_sync u_dat_sync (
    .clock    (clock),
    .reset    (reset),
    .pin_i    (ps2_dat_in),
    .level_o  (dat_level),
    .fall_c_o (dat_fall_unused)
  );

  state_e               state_q;
  logic [FRAME_W-1:0]   shift_q;
  logic [3:0]           bit_q;
  cnt_t                 timer_q;
  logic                 clk_low_q;
  logic                 dat_low_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;
  logic [1:0]           code_q;

  logic                 xfer_phase_c;
  logic                 fail_c;
  logic [1:0]           fail_code_c;
  logic [3:0]           bit_nxt_c;

  // Failure detection; timeouts are checked ahead of the ACK sample so they win.
  always_comb begin
    xfer_phase_c = (state_q == ST_DATA) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    fail_c       = 1'b0;
    fail_code_c  = ERR_NONE;
    if ((state_q == ST_START) && (timer_q == START_LAST)) begin
      fail_c      = 1'b1;
      fail_code_c = ERR_START_TO;
    end else if (xfer_phase_c && (timer_q == XFER_LAST)) begin
      fail_c      = 1'b1;
      fail_code_c = ERR_XFER_TO;
    end else if ((state_q == ST_ACK) && clk_fall && dat_level) begin
      fail_c      = 1'b1;
      fail_code_c = ERR_NO_ACK;
    end
  end

  assign bit_nxt_c = bit_q + 4'd1;

  // One timer serves inhibit, start wait and the whole transfer; phases never overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_q     <= '0;
      timer_q   <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      timer_q <= sat_inc(timer_q);
      if (fail_c) begin
        state_q   <= ST_IDLE;
        clk_low_q <= 1'b0;
        dat_low_q <= 1'b0;
        ready_q   <= 1'b1;
        busy_q    <= 1'b0;
        error_q   <= 1'b1;
        code_q    <= fail_code_c;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (tx_valid) begin
              shift_q   <= frame_bits(tx_data);
              code_q    <= ERR_NONE;
              timer_q   <= '0;
              clk_low_q <= 1'b1;
              dat_low_q <= 1'b0;
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (timer_q == INH_LAST) begin
              clk_low_q <= 1'b0;
              dat_low_q <= 1'b1;
              timer_q   <= '0;
              state_q   <= ST_START;
            end
          end
          ST_START: begin
            if (clk_fall) begin
              bit_q     <= '0;
              dat_low_q <= ~shift_q[0];
              timer_q   <= '0;
              state_q   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (clk_fall) begin
              if (bit_q == PARITY_IDX) begin
                dat_low_q <= 1'b0;
                state_q   <= ST_ACK;
              end else begin
                bit_q     <= bit_nxt_c;
                dat_low_q <= ~shift_q[bit_nxt_c];
              end
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              state_q <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_level && dat_level) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready          = ready_q;
  assign tx_busy           = busy_q;
  assign tx_done           = done_q;
  assign tx_error          = error_q;
  assign tx_err_code       = code_q;
  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking PS/2 device model and
// a frame/outcome reference derived from the protocol rules.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INH  = 10;
  localparam int unsigned STO  = 200;
  localparam int unsigned XTO  = 2000;
  localparam int unsigned HALF = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] tx_err_code;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       dev_clk_hi;
  logic       dev_dat_low;

  always #5 clock = ~clock;

  // Wired-AND bus: either side may pull a line low.
  assign ps2_clk_in = ~ps2_clk_drive_low & dev_clk_hi;
  assign ps2_dat_in = ~ps2_dat_drive_low & ~dev_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (STO),
    .XFER_TIMEOUT_CYCLES  (XTO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .tx_busy           (tx_busy),
    .tx_done           (tx_done),
    .tx_error          (tx_error),
    .tx_err_code       (tx_err_code),
    .ps2_clk_in        (ps2_clk_in),
    .ps2_dat_in        (ps2_dat_in),
    .ps2_clk_drive_low (ps2_clk_drive_low),
    .ps2_dat_drive_low (ps2_dat_drive_low)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   inh_cnt, rel_cyc, fall1_cyc, done_cnt, err_cnt, err_cyc, both_cnt;
  logic prev_clk_drv = 1'b0;
  logic rel_dat, err_lines_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (ps2_clk_drive_low) inh_cnt++;
    if (prev_clk_drv && !ps2_clk_drive_low) begin
      rel_cyc = cyc;
      rel_dat = ps2_dat_drive_low;
    end
    prev_clk_drv = ps2_clk_drive_low;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc       = cyc;
      err_lines_rel = !ps2_clk_drive_low && !ps2_dat_drive_low;
    end
    if (tx_done && tx_error) both_cnt++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_mon();
    inh_cnt = 0; rel_cyc = -1; fall1_cyc = -1; done_cnt = 0;
    err_cnt = 0; err_cyc = -1; both_cnt = 0; rel_dat = 1'b0; err_lines_rel = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  // Device: wait for the request-to-send, then generate nf clock pulses,
  // reading one bit on each rising edge; optionally ACK before the 11th fall.
  task automatic device(input int nf, input bit ack, output logic [9:0] bits, output bit got_req);
    int t;
    bits    = '0;
    t = 0;
    while (ps2_clk_in && t < 100) begin step(); t++; end
    t = 0;
    while (!(ps2_clk_in && !ps2_dat_in) && t < 100) begin step(); t++; end
    got_req = ps2_clk_in && !ps2_dat_in;
    if (!got_req) return;
    steps(5);
    for (int k = 1; k <= nf; k++) begin
      dev_clk_hi = 1'b0;
      if (k == 1) fall1_cyc = cyc;
      steps(HALF);
      dev_clk_hi = 1'b1;
      if (k <= 10) bits[k-1] = ps2_dat_in;
      if (k == 10 && ack) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      steps(HALF);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int t = 0;
    while ((done_cnt + err_cnt) == 0 && t < budget) begin step(); t++; end
    steps(3);
  endtask

  // Expected line bits as seen by the device: data LSB first, odd parity, stop=1.
  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = d[i];
    f[8] = (($countones(d) % 2) == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  function automatic logic [1:0] exp_err(input int nf, input bit ack);
    if (nf == 0)  return ERR_START_TO;
    if (nf < 11)  return ERR_XFER_TO;
    if (!ack)     return ERR_NO_ACK;
    return ERR_NONE;
  endfunction

  task automatic txn(input string tag, input logic [7:0] d, input int nf, input bit ack);
    logic [9:0] bits, mask, expf;
    bit         req;
    logic [1:0] ec;
    clear_mon();
    chk({tag, "_ready"}, 32'(tx_ready), 32'(1));
    send(d);
    chk({tag, "_busy"}, 32'(tx_busy), 32'(1));
    tx_data  = ~d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    device(nf, ack, bits, req);
    chk({tag, "_req"}, 32'(req), 32'(1));
    wait_end(2500);
    ec   = exp_err(nf, ack);
    expf = exp_frame(d);
    mask = (nf >= 10) ? 10'h3FF : 10'((1 << nf) - 1);
    if (nf > 0) chk({tag, "_bits"}, 32'(bits & mask), 32'(expf & mask));
    chk({tag, "_inhibit"}, 32'(inh_cnt), 32'(INH));
    chk({tag, "_startbit"}, 32'(rel_dat), 32'(1));
    chk({tag, "_code"}, 32'(tx_err_code), 32'(ec));
    chk({tag, "_done"}, 32'(done_cnt), 32'(ec == ERR_NONE));
    chk({tag, "_error"}, 32'(err_cnt), 32'(ec != ERR_NONE));
    chk({tag, "_both"}, 32'(both_cnt), 32'(0));
    chk({tag, "_ready_end"}, 32'(tx_ready), 32'(1));
    if (ec != ERR_NONE) chk({tag, "_released"}, 32'(err_lines_rel), 32'(1));
    if (ec == ERR_START_TO) chk({tag, "_start_to_time"}, 32'(err_cyc - rel_cyc), 32'(STO));
    if (ec == ERR_XFER_TO) chk({tag, "_xfer_to_time"}, 32'(err_cyc - fall1_cyc), 32'(XTO + 3));
    clear_mon();
    steps(60);
    chk({tag, "_no_resend"}, 32'(inh_cnt), 32'(0));
  endtask

  initial begin
    logic [9:0] bits;
    bit         req;
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_hi = 1'b1; dev_dat_low = 1'b0;
    clear_mon();
    steps(3);
    chk("reset_outputs", 32'({tx_ready, tx_busy, tx_done, tx_error, tx_err_code,
                              ps2_clk_drive_low, ps2_dat_drive_low}), 32'(8'b1000_0000));
    reset = 1'b0;
    steps(2);

    txn("t1_set_leds", PS2_CMD_SET_LEDS, 11, 1'b1);
    txn("t2_parity0",  8'h01,            11, 1'b1);
    txn("t3_no_ack",   PS2_CMD_ENABLE,   11, 1'b0);
    txn("t4_start_to", PS2_CMD_RESET,    0,  1'b1);
    txn("t5_xfer_to",  8'hA5,            4,  1'b1);

    for (int i = 0; i < 4; i++) begin
      txn($sformatf("rand%0d", i), 8'($urandom), 11, 1'($urandom_range(0, 1)));
    end

    // Reset while the host is driving data bit 3.
    clear_mon();
    send(8'h3C);
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    device(4, 1'b1, bits, req);
    chk("t6_req", 32'(req), 32'(1));
    chk("t6_bits", 32'(bits[3:0]), 32'(4'hC));
    reset = 1'b1;
    step();
    chk("t6_reset_outputs", 32'({tx_ready, tx_busy, tx_done, tx_error, tx_err_code,
                                 ps2_clk_drive_low, ps2_dat_drive_low}), 32'(8'b1000_0000));
    chk("t6_no_pulse", 32'(done_cnt + err_cnt), 32'(0));
    reset = 1'b0;
    clear_mon();
    steps(100);
    chk("t6_no_resend", 32'(inh_cnt), 32'(0));
    chk("t6_quiet", 32'(done_cnt + err_cnt), 32'(0));
    chk("t6_ready", 32'(tx_ready), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
